// File: rtl/meter_display_driver_if.sv
// rtl/meter_display_driver_if.sv - meter value in, display drive and conversion status out
interface meter_display_driver_if;
  logic [15:0] second_count;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] bcd_out;
  logic        conv_busy;

  modport master (
    output second_count,
    input  an, seg, bcd_out, conv_busy
  );

  modport slave (
    input  second_count,
    output an, seg, bcd_out, conv_busy
  );
endinterface

// File: rtl/meter_display_driver.sv
// rtl/meter_display_driver.sv - binary-to-BCD converter feeding a blinking 4-digit 7-segment scanner
module meter_display_driver #(
  parameter int CLOCK_FREQ   = 100000000,
  parameter int DIGIT_PERIOD = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  meter_display_driver_if.slave  bus
);

  localparam logic [31:0] BLINK_LAST = 32'(2 * CLOCK_FREQ - 1);
  localparam logic [31:0] FREQ       = 32'(CLOCK_FREQ);
  localparam logic [31:0] HALF_FREQ  = 32'(CLOCK_FREQ / 2);
  localparam logic [31:0] SCAN_LAST  = 32'(DIGIT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_shift;
  logic [3:0]  r_bitcnt;
  logic [15:0] r_bcd;
  logic [31:0] w_adj;
  logic [15:0] w_sat;

  logic [31:0] r_blink;
  logic [31:0] r_scan_div;
  logic [1:0]  r_digit;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic [31:0] w_blink_mod;
  logic        w_en;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg_code;

  assign w_sat = (bus.second_count > 16'd9999) ? 16'd9999 : bus.second_count;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = SHIFT;
      SHIFT:   if (r_bitcnt == 4'd15) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Double-dabble: correct BCD nibbles in the upper half, then shift the whole word.
  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < 4; i++) begin
      if (r_shift[16 + 4*i +: 4] >= 4'd5)
        w_adj[16 + 4*i +: 4] = r_shift[16 + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_bcd    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_shift  <= {16'd0, w_sat};
          r_bitcnt <= '0;
        end
        SHIFT: begin
          r_shift  <= w_adj << 1;
          r_bitcnt <= r_bitcnt + 4'd1;
        end
        DONE:    r_bcd <= r_shift[31:16];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink    <= '0;
      r_scan_div <= '0;
      r_digit    <= '0;
    end else begin
      r_blink <= (r_blink == BLINK_LAST) ? 32'd0 : r_blink + 32'd1;
      if (r_scan_div == SCAN_LAST) begin
        r_scan_div <= '0;
        r_digit    <= r_digit + 2'd1;
      end else begin
        r_scan_div <= r_scan_div + 32'd1;
      end
    end
  end

  // Enable policy: >=200 steady, 1..199 slow blink, 0 fast blink.
  always_comb begin
    w_blink_mod = (r_blink >= FREQ) ? r_blink - FREQ : r_blink;
    if (r_bcd[15:12] != 4'd0 || r_bcd[11:8] >= 4'd2)
      w_en = 1'b1;
    else if (r_bcd != 16'd0)
      w_en = (r_blink < FREQ);
    else
      w_en = (w_blink_mod < HALF_FREQ);
  end

  always_comb begin
    w_nibble = r_bcd[4*r_digit +: 4];
    case (w_nibble)
      4'd0:    w_seg_code = 7'b1000000;
      4'd1:    w_seg_code = 7'b1111001;
      4'd2:    w_seg_code = 7'b0100100;
      4'd3:    w_seg_code = 7'b0110000;
      4'd4:    w_seg_code = 7'b0011001;
      4'd5:    w_seg_code = 7'b0010010;
      4'd6:    w_seg_code = 7'b0000010;
      4'd7:    w_seg_code = 7'b1111000;
      4'd8:    w_seg_code = 7'b0000000;
      4'd9:    w_seg_code = 7'b0010000;
      default: w_seg_code = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else if (w_en) begin
      r_an  <= ~(4'b0001 << r_digit);
      r_seg <= w_seg_code;
    end else begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end
  end

  assign bus.an        = r_an;
  assign bus.seg       = r_seg;
  assign bus.bcd_out   = r_bcd;
  assign bus.conv_busy = (r_state != IDLE);

endmodule

// File: tb/tb_meter_display_driver.sv
// tb/tb_meter_display_driver.sv - scoreboard and vector-table bench for meter_display_driver
module tb_meter_display_driver;
  localparam int CF = 20;
  localparam int DP = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  meter_display_driver_if bus();

  meter_display_driver #(.CLOCK_FREQ(CF), .DIGIT_PERIOD(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] bcd;
    logic        busy;
  } exp_t;

  typedef struct {
    logic [15:0] sc;
    int          cycles;
    logic [15:0] exp_bcd;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          m_t;
  int          m_cap;
  logic [15:0] m_bcd;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int bcd_val(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model the outputs that the coming edge will produce, then compare after it.
  task automatic step();
    exp_t e;
    int   blink, dig, val;
    logic en;
    if (!rst_n) begin
      e.an = 4'b1111; e.seg = 7'b1111111; e.bcd = 16'd0; e.busy = 1'b0;
      m_t = 0; m_bcd = 16'd0; m_cap = 0;
    end else begin
      blink = m_t % (2 * CF);
      dig   = (m_t / DP) % 4;
      val   = bcd_val(m_bcd);
      if (val >= 200)   en = 1'b1;
      else if (val > 0) en = (blink < CF);
      else              en = ((blink % CF) < CF / 2);
      e.an  = en ? ~(4'b0001 << dig) : 4'b1111;
      e.seg = en ? seg_of(m_bcd[4*dig +: 4]) : 7'b1111111;
      if (m_t % 18 == 0)  m_cap = (int'(bus.second_count) > 9999) ? 9999 : int'(bus.second_count);
      if (m_t % 18 == 17) m_bcd = to_bcd(m_cap);
      e.bcd  = m_bcd;
      e.busy = ((m_t + 1) % 18) != 0;
      m_t++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("an",        32'(bus.an),        32'(e.an));
    chk("seg",       32'(bus.seg),       32'(e.seg));
    chk("bcd_out",   32'(bus.bcd_out),   32'(e.bcd));
    chk("conv_busy", 32'(bus.conv_busy), 32'(e.busy));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'd1234,  40, 16'h1234};
    vecs[1] = '{16'd12000, 60, 16'h9999};
    vecs[2] = '{16'd150,   80, 16'h0150};
    vecs[3] = '{16'd0,     80, 16'h0000};
    vecs[4] = '{16'd9999,  40, 16'h9999};
    vecs[5] = '{16'd10000, 40, 16'h9999};
    vecs[6] = '{16'hFFFF,  40, 16'h9999};
    vecs[7] = '{16'd200,   50, 16'h0200};
    vecs[8] = '{16'd199,   50, 16'h0199};
    vecs[9] = '{16'd7,     50, 16'h0007};

    rst_n = 1'b0;
    bus.second_count = 16'd1234;
    step();
    step();
    chk("rst_an",   32'(bus.an),        32'h0000000F);
    chk("rst_seg",  32'(bus.seg),       32'h0000007F);
    chk("rst_bcd",  32'(bus.bcd_out),   32'h00000000);
    chk("rst_busy", 32'(bus.conv_busy), 32'h00000000);

    rst_n = 1'b1;
    repeat (17) step();
    chk("first_conv_pending", 32'(bus.bcd_out), 32'h00000000);
    step();
    chk("first_conv_done", 32'(bus.bcd_out), 32'h00001234);
    bus.second_count = 16'd5555;
    repeat (10) step();
    chk("ignore_mid_conv", 32'(bus.bcd_out), 32'h00001234);

    for (int i = 0; i < 10; i++) begin
      bus.second_count = vecs[i].sc;
      repeat (vecs[i].cycles) step();
      chk($sformatf("vec%0d_bcd", i), 32'(bus.bcd_out), 32'(vecs[i].exp_bcd));
    end

    bus.second_count = 16'd777;
    for (int n = 0; n < 40 && (m_t % 18) != 8; n++) step();
    chk("abort_phase_reached", 32'(bus.conv_busy), 32'h00000001);
    rst_n = 1'b0;
    bus.second_count = 16'd4321;
    step();
    chk("abort_bcd",  32'(bus.bcd_out),   32'h00000000);
    chk("abort_busy", 32'(bus.conv_busy), 32'h00000000);
    rst_n = 1'b1;
    repeat (17) step();
    chk("after_abort_pending", 32'(bus.bcd_out), 32'h00000000);
    step();
    chk("after_abort_done", 32'(bus.bcd_out), 32'h00004321);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
